// File: rtl/prio_enc_core.sv
// Combinational highest-set-bit encoder: a -> index y, any-set flag, one-hot winner.
// Scales to any power-of-two N by scanning upward so the highest set bit wins.
module prio_enc_core #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] a,
  output logic [W-1:0] y,
  output logic         valid,
  output logic [N-1:0] onehot
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    y     = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (a[i]) begin
        y     = W'(i);
        valid = 1'b1;
      end
    end
    onehot = valid ? (N'(1) << y) : '0;
  end

endmodule

// File: rtl/priority_encoder.sv
// Priority encoder top: combinational encode plus a one-cycle registered copy
// of every output, cleared by a synchronous active-high reset.
module priority_encoder #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] a,
  output logic [W-1:0] y,
  output logic         valid,
  output logic [N-1:0] onehot,
  output logic [W-1:0] y_q,
  output logic         valid_q,
  output logic [N-1:0] onehot_q
);

  prio_enc_core #(.N(N)) u_core (
    .a      (a),
    .y      (y),
    .valid  (valid),
    .onehot (onehot)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      y_q      <= '0;
      valid_q  <= 1'b0;
      onehot_q <= '0;
    end else begin
      y_q      <= y;
      valid_q  <= valid;
      onehot_q <= onehot;
    end
  end

endmodule

// File: tb/tb_priority_encoder.sv
// Directed self-checking bench for priority_encoder at N=4 and N=8.
`timescale 1ns/1ps
module tb_priority_encoder;

  logic       clk;
  logic       reset;
  logic [3:0] a4;
  logic [1:0] y4, y4_q;
  logic       v4, v4_q;
  logic [3:0] oh4, oh4_q;
  logic [7:0] a8;
  logic [2:0] y8, y8_q;
  logic       v8, v8_q;
  logic [7:0] oh8, oh8_q;

  int asserts;
  int fails;

  priority_encoder #(.N(4)) dut4 (
    .clk      (clk),
    .reset    (reset),
    .a        (a4),
    .y        (y4),
    .valid    (v4),
    .onehot   (oh4),
    .y_q      (y4_q),
    .valid_q  (v4_q),
    .onehot_q (oh4_q)
  );

  priority_encoder #(.N(8)) dut8 (
    .clk      (clk),
    .reset    (reset),
    .a        (a8),
    .y        (y8),
    .valid    (v8),
    .onehot   (oh8),
    .y_q      (y8_q),
    .valid_q  (v8_q),
    .onehot_q (oh8_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: scan from the top bit down, first set bit is the answer.
  function automatic int hsb8(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return i;
    return 0;
  endfunction

  initial begin
    int exp_y [16];
    int eh;
    exp_y = '{0, 0, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3, 3};
    asserts = 0;
    fails   = 0;
    reset   = 1'b1;
    a4      = 4'b1010;
    a8      = 8'h00;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    check("rst_y_q",      64'(y4_q),  64'd0);
    check("rst_valid_q",  64'(v4_q),  64'd0);
    check("rst_onehot_q", 64'(oh4_q), 64'd0);
    check("rst_comb_y",   64'(y4),    64'd3);
    check("rst_comb_v",   64'(v4),    64'd1);

    @(negedge clk);
    reset = 1'b0;
    a4    = 4'b0000;

    // Exhaustive N=4 sweep, checked 10 ps after each change
    for (int i = 0; i < 16; i++) begin
      a4 = 4'(i);
      #10ps;
      check($sformatf("sweep_y a=%0d", i),     64'(y4),  64'(exp_y[i]));
      check($sformatf("sweep_valid a=%0d", i), 64'(v4),  64'(i != 0));
      check($sformatf("sweep_oh a=%0d", i),    64'(oh4), (i != 0) ? (64'd1 << exp_y[i]) : 64'd0);
    end

    // Priority masking
    a4 = 4'b1111; #10ps;
    check("mask_1111_y",  64'(y4),  64'd3);
    check("mask_1111_oh", 64'(oh4), 64'b1000);
    a4 = 4'b0110; #10ps;
    check("mask_0110_y",  64'(y4),  64'd2);
    check("mask_0110_oh", 64'(oh4), 64'b0100);
    a4 = 4'b0001; #10ps;
    check("mask_0001_y",  64'(y4),  64'd0);
    check("mask_0001_v",  64'(v4),  64'd1);
    check("mask_0001_oh", 64'(oh4), 64'b0001);

    // Register latency: bit 0 captured first, then a=0100 at edge k
    @(negedge clk); a4 = 4'b0001;
    @(posedge clk); #1;
    check("lat_pre_y_q", 64'(y4_q), 64'd0);
    check("lat_pre_v_q", 64'(v4_q), 64'd1);
    @(negedge clk); a4 = 4'b0100; #1;
    check("lat_before_k_y_q",  64'(y4_q),  64'd0);
    check("lat_before_k_oh_q", 64'(oh4_q), 64'b0001);
    @(posedge clk); #1;
    check("lat_k_y_q",  64'(y4_q),  64'd2);
    check("lat_k_v_q",  64'(v4_q),  64'd1);
    check("lat_k_oh_q", 64'(oh4_q), 64'b0100);

    // Reset mid-stream
    @(negedge clk); a4 = 4'b1000;
    @(posedge clk); #1;
    check("mid_cap_y_q", 64'(y4_q), 64'd3);
    @(negedge clk); reset = 1'b1; #1;
    check("mid_no_async_y_q", 64'(y4_q), 64'd3);
    check("mid_no_async_v_q", 64'(v4_q), 64'd1);
    check("mid_comb_y_rst",   64'(y4),   64'd3);
    @(posedge clk); #1;
    check("mid_rst_y_q",  64'(y4_q),  64'd0);
    check("mid_rst_v_q",  64'(v4_q),  64'd0);
    check("mid_rst_oh_q", 64'(oh4_q), 64'd0);
    check("mid_comb_y",   64'(y4),    64'd3);
    check("mid_comb_oh",  64'(oh4),   64'b1000);
    @(negedge clk); reset = 1'b0; #1;
    check("mid_hold_y_q", 64'(y4_q), 64'd0);
    @(posedge clk); #1;
    check("mid_rel_y_q",  64'(y4_q),  64'd3);
    check("mid_rel_v_q",  64'(v4_q),  64'd1);
    check("mid_rel_oh_q", 64'(oh4_q), 64'b1000);
    check("mid_rel_y",    64'(y4),    64'd3);

    // N=8 scaling
    @(negedge clk);
    a8 = 8'h80; #10ps;
    check("n8_80_y",  64'(y8),  64'd7);
    check("n8_80_oh", 64'(oh8), 64'h80);
    a8 = 8'h01; #10ps;
    check("n8_01_y", 64'(y8), 64'd0);
    check("n8_01_v", 64'(v8), 64'd1);
    a8 = 8'h00; #10ps;
    check("n8_00_v",  64'(v8),  64'd0);
    check("n8_00_y",  64'(y8),  64'd0);
    check("n8_00_oh", 64'(oh8), 64'd0);
    a8 = 8'h5a; #10ps;
    check("n8_5a_y", 64'(y8), 64'd6);
    @(posedge clk); #1;
    check("n8_5a_y_q",  64'(y8_q),  64'd6);
    check("n8_5a_oh_q", 64'(oh8_q), 64'h40);
    check("n8_5a_v_q",  64'(v8_q),  64'd1);

    for (int s = 0; s < 1000; s++) begin
      a8 = 8'($urandom);
      #10ps;
      eh = hsb8(a8);
      check($sformatf("n8_rand_y a=%02h", a8),  64'(y8), 64'(eh));
      check($sformatf("n8_rand_v a=%02h", a8),  64'(v8), 64'(a8 != 8'h00));
      check($sformatf("n8_rand_oh a=%02h", a8), 64'(oh8), (a8 != 8'h00) ? (64'd1 << eh) : 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
